// File: rtl/disp_mux_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : disp_mux_n_if
//  Description : Core-side value/control bus and board-side digit/segment bus
//                of the multiplexed 7-segment display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface disp_mux_n_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
);
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    lz_suppress;
    logic                    blank;
    logic [BRIGHT_W-1:0]     brightness;
    logic                    frame_start;
    logic [7:0]              digit;
    logic [7:0]              segment;

    modport master (
        output disp_val, dp_in, load, lz_suppress, blank, brightness,
        input  frame_start, digit, segment
    );

    modport slave (
        input  disp_val, dp_in, load, lz_suppress, blank, brightness,
        output frame_start, digit, segment
    );
endinterface
`default_nettype wire

// File: rtl/disp_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : disp_mux_n
//  Description : Time-multiplexed common-anode 7-segment driver with frame-
//                synchronous loading, leading-zero blanking and PWM dimming.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_mux_n #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1250,
    parameter int BRIGHT_W   = 3
) (
    input  wire logic     clock5,
    input  wire logic     reset,
    disp_mux_n_if.slave   bus
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PROD_W = BRIGHT_W + 1 + $clog2(CLK_DIV + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]             r_count;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_frame_start;
    logic [NUM_DIGITS-1:0][3:0]   r_pend_val;
    logic [NUM_DIGITS-1:0]        r_pend_dp;
    logic                         r_pend_valid;
    logic [NUM_DIGITS-1:0][3:0]   r_shadow_val;
    logic [NUM_DIGITS-1:0]        r_shadow_dp;
    logic [7:0]                   r_digit;
    logic [7:0]                   r_segment;

    logic                         w_tick;
    logic                         w_wrap;
    logic [NUM_DIGITS-1:0]        w_hi_zero;
    logic [3:0]                   w_cur_nib;
    logic                         w_cur_dp;
    logic                         w_suppressed;
    logic [PROD_W-1:0]            w_on_time;
    logic                         w_in_on;
    logic                         w_lit;
    logic [6:0]                   w_seg_pat;
    logic [7:0]                   w_digit_sel;

    assign w_tick = (r_count == LAST_CNT);
    assign w_wrap = w_tick && (r_idx == LAST_IDX);

    always_ff @(posedge clock5 or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_idx         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_tick) begin
                r_count <= '0;
                r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // A load coinciding with the wrap tick lands in pending; shadow still
    // takes the previous pending value so a frame never shows a mix.
    always_ff @(posedge clock5 or posedge reset) begin
        if (reset) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
        end else begin
            if (w_wrap && r_pend_valid) begin
                r_shadow_val <= r_pend_val;
                r_shadow_dp  <= r_pend_dp;
            end
            if (bus.load) begin
                r_pend_val   <= bus.disp_val;
                r_pend_dp    <= bus.dp_in;
                r_pend_valid <= 1'b1;
            end else if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // w_hi_zero[i]: nibble i and every nibble above it are zero.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        w_hi_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc          = acc & (r_shadow_val[i] == 4'h0);
            w_hi_zero[i] = acc;
        end
    end

    assign w_cur_nib    = r_shadow_val[r_idx];
    assign w_cur_dp     = r_shadow_dp[r_idx];
    assign w_suppressed = bus.lz_suppress && (r_idx != '0) && w_hi_zero[r_idx];

    assign w_on_time = ((PROD_W'(bus.brightness) + PROD_W'(1)) * PROD_W'(CLK_DIV)) >> BRIGHT_W;
    assign w_in_on   = PROD_W'(r_count) < w_on_time;
    assign w_lit     = !bus.blank && !w_suppressed && w_in_on;

    // Active-high a..g patterns; inverted when driven onto the pins.
    always_comb begin
        w_seg_pat = 7'b0000000;
        case (w_cur_nib)
            4'h0: w_seg_pat = 7'b1111110;
            4'h1: w_seg_pat = 7'b0110000;
            4'h2: w_seg_pat = 7'b1101101;
            4'h3: w_seg_pat = 7'b1111001;
            4'h4: w_seg_pat = 7'b0110011;
            4'h5: w_seg_pat = 7'b1011011;
            4'h6: w_seg_pat = 7'b1011111;
            4'h7: w_seg_pat = 7'b1110000;
            4'h8: w_seg_pat = 7'b1111111;
            4'h9: w_seg_pat = 7'b1111011;
            4'hA: w_seg_pat = 7'b1110111;
            4'hB: w_seg_pat = 7'b0011111;
            4'hC: w_seg_pat = 7'b1001110;
            4'hD: w_seg_pat = 7'b0111101;
            4'hE: w_seg_pat = 7'b1001111;
            4'hF: w_seg_pat = 7'b1000111;
            default: w_seg_pat = 7'b0000000;
        endcase
    end

    assign w_digit_sel = 8'b0000_0001 << r_idx;

    always_ff @(posedge clock5 or posedge reset) begin
        if (reset) begin
            r_digit   <= 8'hFF;
            r_segment <= 8'hFF;
        end else if (w_lit) begin
            r_digit   <= ~w_digit_sel;
            r_segment <= {~w_seg_pat, ~w_cur_dp};
        end else begin
            r_digit   <= 8'hFF;
            r_segment <= 8'hFF;
        end
    end

    assign bus.frame_start = r_frame_start;
    assign bus.digit       = r_digit;
    assign bus.segment     = r_segment;

endmodule
`default_nettype wire

// File: tb/tb_disp_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_mux_n
//  Description : Randomised self-checking bench for disp_mux_n against a
//                time-indexed behavioural display model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_mux_n;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BW = 3;
    localparam int FR = ND * CD;

    logic clock5 = 1'b0;
    logic reset  = 1'b1;
    always #5 clock5 = ~clock5;

    disp_mux_n_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

    disp_mux_n #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BRIGHT_W(BW)) dut (
        .clock5 (clock5),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        int              t;
        logic [4*ND-1:0] v;
        logic [ND-1:0]   dp;
    } load_t;

    load_t loads[$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    t       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, t);
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Value on show in cycle tc: the last load strictly before the wrap-tick
    // cycle that opened the current frame.
    task automatic shadow_at(input int tc, output logic [4*ND-1:0] v, output logic [ND-1:0] dp);
        int b;
        b  = (tc / FR) * FR;
        v  = '0;
        dp = '0;
        if (b > 0) begin
            foreach (loads[i]) begin
                if (loads[i].t <= b - 2) begin
                    v  = loads[i].v;
                    dp = loads[i].dp;
                end
            end
        end
    endtask

    task automatic step();
        logic            lz_s, bl_s, ld_s, lit, sup;
        logic [BW-1:0]   br_s;
        logic [4*ND-1:0] v_s, sv;
        logic [ND-1:0]   dp_s, sdp;
        logic [3:0]      nib;
        logic [7:0]      ed, es;
        int              slot, phase, on;
        lz_s = bus.lz_suppress;
        bl_s = bus.blank;
        ld_s = bus.load;
        br_s = bus.brightness;
        v_s  = bus.disp_val;
        dp_s = bus.dp_in;
        @(posedge clock5);
        if (ld_s) loads.push_back('{t, v_s, dp_s});
        shadow_at(t, sv, sdp);
        slot  = (t / CD) % ND;
        phase = t % CD;
        nib   = sv[4*slot +: 4];
        sup   = lz_s && (slot > 0) && ((sv >> (4*slot)) == '0);
        on    = ((int'(br_s) + 1) * CD) >> BW;
        lit   = !bl_s && !sup && (phase < on);
        ed    = lit ? ~(8'(1) << slot) : 8'hFF;
        es    = lit ? {~seg7(nib), ~sdp[slot]} : 8'hFF;
        #1;
        check("digit", 32'(bus.digit), 32'(ed));
        check("segment", 32'(bus.segment), 32'(es));
        check("frame_start", 32'(bus.frame_start), 32'((t + 1) % FR == 0));
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [4*ND-1:0] v, input logic [ND-1:0] dp);
        bus.disp_val = v;
        bus.dp_in    = dp;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic run_to_phase(input int ph);
        for (int k = 0; k < FR && (t % FR) != ph; k++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.disp_val    = '0;
        bus.dp_in       = '0;
        bus.load        = 1'b0;
        bus.lz_suppress = 1'b0;
        bus.blank       = 1'b0;
        bus.brightness  = 3'd7;

        repeat (3) begin
            @(posedge clock5);
            #1;
            check("rst_digit", 32'(bus.digit), 32'hFF);
            check("rst_segment", 32'(bus.segment), 32'hFF);
            check("rst_frame_start", 32'(bus.frame_start), 32'h0);
        end
        #4 reset = 1'b0;
        t = 0;

        run(40);
        do_load(16'h12AF, 4'b0100);
        run(100);

        bus.lz_suppress = 1'b1;
        do_load(16'h0030, 4'b0000);
        run(70);
        do_load(16'h0000, 4'b1111);
        run(70);

        bus.lz_suppress = 1'b0;
        do_load(16'h8E5D, 4'b1010);
        run(40);
        bus.brightness = 3'd1;
        run(40);
        bus.brightness = 3'd7;
        run(40);

        run_to_phase(3);
        do_load(16'h1111, 4'b0000);
        run_to_phase(FR - 1);
        do_load(16'h2222, 4'b0000);
        run(80);

        for (int k = 0; k < 800; k++) begin
            bus.disp_val = 16'($urandom);
            bus.dp_in    = 4'($urandom);
            bus.load     = ($urandom_range(0, 15) == 0);
            bus.blank    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) bus.lz_suppress = ~bus.lz_suppress;
            if ($urandom_range(0, 39) == 0) bus.brightness = 3'($urandom);
            if ($urandom_range(0, 3) == 0) bus.disp_val = bus.disp_val & 16'h00F0;
            step();
        end

        bus.load        = 1'b0;
        bus.blank       = 1'b0;
        bus.lz_suppress = 1'b0;
        bus.brightness  = 3'd7;
        do_load(16'h4321, 4'b0110);
        run(2 * FR);
        run_to_phase(2 * CD + 2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_digit", 32'(bus.digit), 32'hFF);
        check("async_rst_segment", 32'(bus.segment), 32'hFF);
        check("async_rst_frame_start", 32'(bus.frame_start), 32'h0);
        #1 reset = 1'b0;
        t = 0;
        loads.delete();
        run(70);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
